spi_master_tx: RTL and testbench
================================

Name: spi_master_tx

Overview:
- SPI mode-0 master that serialises bytes onto MOSI, generates SClk and drives an active-low chip select.
- Counterpart to the SPI slave receiver. It drives the slave's SClk/MOSI pins on-board and in loopback benches.
- Fed by the image-processing datapath through a valid/ready byte handshake.
- MSB first, one byte per chip-select frame.

Parameters:
- DATA_W, 8: frame width in bits; must be at least 2.
- CLK_DIV, 4: SClk half-period in Clk cycles; must be at least 1. SClk frequency = Clk / (2*CLK_DIV).

Ports:
- Clk  input  1  system clock; all logic on the rising edge.
- Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- Tx_Data  input  DATA_W  byte to send; captured on accept.
- Tx_Valid  input  1  producer has data.
- Tx_Ready  output  1  block can accept a byte; high only in IDLE.
- SClk  output  1  serial clock; idles low.
- MOSI  output  1  serial data out.
- CS_n  output  1  chip select, active low.
- Busy  output  1  high from accept until the Done cycle, exclusive.
- Done  output  1  one-cycle pulse when a frame completes.
- MISO  input  1  serial data in; used only with the optional feature.
- Rx_Data  output  DATA_W  received byte.
- Rx_Valid  output  1  one-cycle pulse with Rx_Data.

Behaviour:
- Reset (Reset=0, asynchronous, any time including mid-frame):
  - state=IDLE, SClk=0, CS_n=1, MOSI=0, Busy=0, Done=0, Rx_Data=0, Rx_Valid=0.
  - Shift register and counters cleared.
  - Tx_Ready=1 once state is IDLE (it is decoded from state).
  - A partial frame is abandoned and no Done pulse is produced.
- States: IDLE, SETUP, SHIFT, HOLD.
- Accept: Tx_Valid && Tx_Ready sampled at rising edge k.
  - Tx_Data is loaded into the shift register.
  - Changes to Tx_Data after the accept edge are ignored.
  - Tx_Valid while not in IDLE is ignored. There is no buffering and no error is flagged.
- Edge k: IDLE -> SETUP. CS_n=0, MOSI=Tx_Data[DATA_W-1], Busy=1, SClk=0.
- Half-period tick: occurs every CLK_DIV cycles, counted from the accept edge.
- Edge k+CLK_DIV: SETUP -> SHIFT. SClk rises; this is the 1st sample edge for the slave.
- Edge k+2*CLK_DIV*n (n=1..DATA_W-1): SClk falls and MOSI advances to the next lower bit on that same edge. MOSI is therefore stable for CLK_DIV cycles before each rising edge.
- Edge k+(2n+1)*CLK_DIV: SClk rises.
- Edge k+2*DATA_W*CLK_DIV: final fall. SHIFT -> HOLD, MOSI=0, SClk=0, CS_n still 0.
- Edge k+(2*DATA_W+1)*CLK_DIV: HOLD -> IDLE. CS_n=1, Busy=0, Done=1 for one cycle, Tx_Ready=1.
- Back-to-back frames: Tx_Valid held high is accepted on the first IDLE edge. CS_n is high for exactly 1 Clk cycle between frames.
- Bit counter: width $clog2(DATA_W)+1. It counts falling edges and does not wrap within a frame.
- Divider counter:
  - Width $clog2(CLK_DIV)+1.
  - Resets to 0 on accept and on every tick.
  - Held at 0 in IDLE.
- CLK_DIV=1: SClk toggles every Clk cycle and the timing above holds unchanged.
- SClk, MOSI and CS_n are registered outputs, with no combinational paths from inputs.

Optional Feature:
- Macro: SPI_MASTER_RX_CAPTURE_EN.
- Defined:
  - MISO is shifted into an Rx shift register, MSB first, on each cycle that SClk rises (same edge as the rising tick).
  - On the HOLD->IDLE edge, Rx_Data is loaded with the assembled byte and Rx_Valid pulses for one cycle, coincident with Done.
  - Rx_Data holds its value until the next completed frame.
- Undefined:
  - MISO is unused, and Rx_Data=0 and Rx_Valid=0 permanently.
  - No Rx registers are synthesised.

Decomposition:
- Shared package spi_pkg holds:
  - State encoding constants (IDLE=2'd0, SETUP=2'd1, SHIFT=2'd2, HOLD=2'd3).
  - Default DATA_W=8.
  - SPI mode constant (CPOL=0, CPHA=0).
  - This package is also used by the slave.
- One sub-module, spi_clk_div: parameter CLK_DIV; inputs Clk, Reset, enable, restart; output tick pulse every CLK_DIV enabled cycles.
- The FSM, shift registers and output registers live in spi_master_tx.

Test Plan:
- Reset, then Tx_Data=8'hB7 with Tx_Valid high for 1 cycle, CLK_DIV=4:
  - MOSI sampled at the 8 SClk rising edges reads 1,0,1,1,0,1,1,1.
  - CS_n is low for exactly 68 cycles.
  - Done pulses once, 68 cycles after accept.
- Loopback with the SPI slave receiver, Tx_Data=8'h5A then 8'hFF back-to-back:
  - Slave reports 8'h5A then 8'hFF.
  - CS_n is high for exactly 1 cycle between frames.
- Tx_Valid pulsed high with Tx_Data=8'h00 at cycle 10 after accept of 8'hC3:
  - Second request ignored; only 8'hC3 is transmitted.
  - Tx_Ready stays low until Done.
- Reset driven low asynchronously mid-byte, after the 3rd SClk rise:
  - Within the same time step: CS_n=1, SClk=0, MOSI=0, Busy=0.
  - No Done pulse.
  - The next frame of 8'hA5 transmits correctly.
- CLK_DIV=1, Tx_Data=8'h81: SClk toggles every Clk cycle and MOSI sequence is 1,0,0,0,0,0,0,1.
- With SPI_MASTER_RX_CAPTURE_EN, MISO driven as 8'h3C MSB first, changing on SClk falling edges:
  - Rx_Data=8'h3C, and Rx_Valid pulses coincident with Done.
  - Without the macro, Rx_Valid never asserts.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, default frame width and bus mode.
// Used by both the SPI master transmitter and the SPI slave receiver.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } spi_state_e;

    localparam int DEFAULT_DATA_W = 8;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    // Mode 0: SClk idles low, data sampled on the rising edge.
    localparam spi_mode_t SPI_MODE = '{cpol: 1'b0, cpha: 1'b0};

    // Bit counter has to hold DATA_W itself, so one bit more than log2.
    function automatic int cnt_width(input int max_count);
        return $clog2(max_count) + 1;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period divider for the SPI master: pulses tick every CLK_DIV enabled
// cycles, counted from the last restart.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic Clk,
    input  logic Reset,
    input  logic enable,
    input  logic restart,
    output logic tick
);

    localparam int              CW   = cnt_width(CLK_DIV);
    localparam logic [CW-1:0]   LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = enable && (cnt == LAST);

    // NOTE: every register here and in the master gets an explicit value in the
    // asynchronous reset branch, so a mid-frame reset returns to a known state.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt <= '0;
        end else if (restart || tick || !enable) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 master transmitter: MSB-first, one DATA_W-bit word per CS_n frame.
// Optional MISO capture into Rx_Data is enabled by SPI_MASTER_RX_CAPTURE_EN.
module spi_master_tx
    import spi_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int CLK_DIV = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] Tx_Data,
    input  logic              Tx_Valid,
    output logic              Tx_Ready,
    output logic              SClk,
    output logic              MOSI,
    output logic              CS_n,
    output logic              Busy,
    output logic              Done,
    input  logic              MISO,
    output logic [DATA_W-1:0] Rx_Data,
    output logic              Rx_Valid
);

    localparam int            BW       = cnt_width(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
    localparam logic          SCLK_LO  = SPI_MODE.cpol;
    localparam logic          SCLK_HI  = ~SPI_MODE.cpol;

    spi_state_e        state, state_next;
    logic [DATA_W-1:0] shreg, shreg_next;
    logic [BW-1:0]     bit_cnt, bit_cnt_next;
    logic              sclk_next;
    logic              cs_n_next;
    logic              busy_next;
    logic              done_next;
    logic              accept;
    logic              tick;
    logic              rise;
    logic              finish;

    assign Tx_Ready = (state == IDLE);
    assign accept   = Tx_Valid && Tx_Ready;

    // The shift register drains with zero fill, so its MSB is already 0 once
    // the last bit has gone out and MOSI can come straight from the flop.
    assign MOSI = shreg[DATA_W-1];

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .Clk     (Clk),
        .Reset   (Reset),
        .enable  (state != IDLE),
        .restart (accept),
        .tick    (tick)
    );

    // NOTE: every signal assigned below gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next   = state;
        shreg_next   = shreg;
        bit_cnt_next = bit_cnt;
        sclk_next    = SClk;
        cs_n_next    = CS_n;
        busy_next    = Busy;
        done_next    = 1'b0;
        rise         = 1'b0;
        finish       = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_next   = SETUP;
                    shreg_next   = Tx_Data;
                    bit_cnt_next = '0;
                    sclk_next    = SCLK_LO;
                    cs_n_next    = 1'b0;
                    busy_next    = 1'b1;
                end
            end
            SETUP: begin
                if (tick) begin
                    state_next = SHIFT;
                    sclk_next  = SCLK_HI;
                    rise       = 1'b1;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (SClk == SCLK_LO) begin
                        sclk_next = SCLK_HI;
                        rise      = 1'b1;
                    end else begin
                        // Falling edge: advance MOSI one bit; the last fall ends the frame.
                        sclk_next    = SCLK_LO;
                        shreg_next   = {shreg[DATA_W-2:0], 1'b0};
                        bit_cnt_next = bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state_next = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    state_next = IDLE;
                    cs_n_next  = 1'b1;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    finish     = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the values computed before this clock edge.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            SClk    <= SCLK_LO;
            CS_n    <= 1'b1;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            state   <= state_next;
            shreg   <= shreg_next;
            bit_cnt <= bit_cnt_next;
            SClk    <= sclk_next;
            CS_n    <= cs_n_next;
            Busy    <= busy_next;
            Done    <= done_next;
        end
    end

`ifdef SPI_MASTER_RX_CAPTURE_EN
    logic [DATA_W-1:0] rx_shreg;

    // MISO is sampled on the same edge that raises SClk, i.e. the slave's
    // data has been stable for a full half-period.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rx_shreg <= '0;
            Rx_Data  <= '0;
            Rx_Valid <= 1'b0;
        end else begin
            Rx_Valid <= finish;
            if (rise) begin
                rx_shreg <= {rx_shreg[DATA_W-2:0], MISO};
            end
            if (finish) begin
                Rx_Data <= rx_shreg;
            end
        end
    end
`else
    logic unused_rx;

    assign unused_rx = ^{MISO, rise, finish};
    assign Rx_Data   = '0;
    assign Rx_Valid  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx: CLK_DIV=4 and CLK_DIV=1 instances, with a
// behavioural mode-0 slave that samples MOSI on SClk rises and drives MISO.
module tb_spi_master_tx;

`ifdef SPI_MASTER_RX_CAPTURE_EN
    localparam bit RX_EN = 1'b1;
`else
    localparam bit RX_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic [7:0] tx_data4 = '0;
    logic       tx_valid4 = 1'b0;
    logic       tx_ready4, sclk4, mosi4, cs_n4, busy4, done4, rx_valid4;
    logic       miso4 = 1'b0;
    logic [7:0] rx_data4;

    logic [7:0] tx_data1 = '0;
    logic       tx_valid1 = 1'b0;
    logic       tx_ready1, sclk1, mosi1, cs_n1, busy1, done1, rx_valid1;
    logic       miso1 = 1'b0;
    logic [7:0] rx_data1;

    int checks = 0;
    int errors = 0;

    // Slave/monitor state for the CLK_DIV=4 instance
    logic       sclk4_q = 1'b0;
    logic       cs_n4_q = 1'b1;
    logic [7:0] word4 = '0;
    int         bits4 = 0;
    int         cs_low4 = 0;
    int         done_cnt4 = 0;
    int         rxv_cnt4 = 0;
    int         hi_run4 = 0;
    int         last_gap4 = 0;
    logic [7:0] frames4 [$];
    logic [7:0] miso_word = '0;
    int         miso_idx = 7;

    // Monitor state for the CLK_DIV=1 instance
    logic       sclk1_q = 1'b0;
    logic       cs_n1_q = 1'b1;
    logic [7:0] word1 = '0;
    int         bits1 = 0;
    int         tog1 = 0;
    int         done_cnt1 = 0;

    always #5 clk = ~clk;

    spi_master_tx #(.DATA_W(8), .CLK_DIV(4)) u_div4 (
        .Clk(clk), .Reset(rst_n), .Tx_Data(tx_data4), .Tx_Valid(tx_valid4),
        .Tx_Ready(tx_ready4), .SClk(sclk4), .MOSI(mosi4), .CS_n(cs_n4),
        .Busy(busy4), .Done(done4), .MISO(miso4), .Rx_Data(rx_data4),
        .Rx_Valid(rx_valid4)
    );

    spi_master_tx #(.DATA_W(8), .CLK_DIV(1)) u_div1 (
        .Clk(clk), .Reset(rst_n), .Tx_Data(tx_data1), .Tx_Valid(tx_valid1),
        .Tx_Ready(tx_ready1), .SClk(sclk1), .MOSI(mosi1), .CS_n(cs_n1),
        .Busy(busy1), .Done(done1), .MISO(miso1), .Rx_Data(rx_data1),
        .Rx_Valid(rx_valid1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling clock edge and update both monitors.
    task automatic cycle();
        @(negedge clk);
        if (!cs_n4) cs_low4++;
        if (done4) done_cnt4++;
        if (rx_valid4) rxv_cnt4++;
        if (!cs_n4 && sclk4 && !sclk4_q) begin
            word4 = {word4[6:0], mosi4};
            bits4++;
        end
        if (cs_n4 && !cs_n4_q) begin
            if (bits4 == 8) frames4.push_back(word4);
            bits4 = 0;
        end
        if (cs_n4) begin
            hi_run4++;
        end else begin
            if (cs_n4_q) last_gap4 = hi_run4;
            hi_run4 = 0;
        end
        if (!cs_n4 && sclk4_q && !sclk4 && miso_idx > 0) miso_idx--;
        miso4 = miso_word[miso_idx];
        sclk4_q = sclk4;
        cs_n4_q = cs_n4;

        if (done1) done_cnt1++;
        if (!cs_n1 && !cs_n1_q && (sclk1 != sclk1_q)) tog1++;
        if (!cs_n1 && sclk1 && !sclk1_q) begin
            word1 = {word1[6:0], mosi1};
            bits1++;
        end
        sclk1_q = sclk1;
        cs_n1_q = cs_n1;
    endtask

    // One frame on the CLK_DIV=4 instance; lat = cycles from accept to Done.
    task automatic send4(input logic [7:0] d, output int lat);
        tx_data4  = d;
        tx_valid4 = 1'b1;
        cycle();
        check("accept_cs_n", cs_n4, 1'b0);
        check("accept_mosi_msb", mosi4, d[7]);
        check("accept_busy", busy4, 1'b1);
        tx_valid4 = 1'b0;
        tx_data4  = ~d;
        lat = 0;
        while (!done4 && lat < 300) begin
            cycle();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int n;
        int early_ready;

        // Reset state
        repeat (3) cycle();
        check("rst_cs_n", cs_n4, 1'b1);
        check("rst_sclk", sclk4, 1'b0);
        check("rst_mosi", mosi4, 1'b0);
        check("rst_busy", busy4, 1'b0);
        check("rst_done", done4, 1'b0);
        check("rst_tx_ready", tx_ready4, 1'b1);
        check("rst_rx", {rx_valid4, rx_data4}, 9'h0);
        rst_n = 1'b1;
        cycle();

        // Single frame 0xB7: bits 1,0,1,1,0,1,1,1 at the rises, 68-cycle frame
        frames4.delete(); cs_low4 = 0; done_cnt4 = 0;
        send4(8'hB7, lat);
        check("b7_done_latency", lat, 68);
        check("b7_busy_at_done", busy4, 1'b0);
        check("b7_ready_at_done", tx_ready4, 1'b1);
        repeat (5) cycle();
        check("b7_cs_low_cycles", cs_low4, 68);
        check("b7_done_pulses", done_cnt4, 1);
        check("b7_frames", frames4.size(), 1);
        if (frames4.size() > 0) check("b7_mosi_bits", frames4[0], 8'hB7);

        // Back-to-back 0x5A, 0xFF with Tx_Valid held high
        frames4.delete(); done_cnt4 = 0;
        tx_data4 = 8'h5A; tx_valid4 = 1'b1;
        cycle();
        tx_data4 = 8'hFF;
        n = 0;
        while (done_cnt4 == 0 && n < 300) begin cycle(); n++; end
        cycle();
        tx_valid4 = 1'b0;
        n = 0;
        while (done_cnt4 < 2 && n < 300) begin cycle(); n++; end
        check("b2b_done_count", done_cnt4, 2);
        check("b2b_cs_high_gap", last_gap4, 1);
        check("b2b_frames", frames4.size(), 2);
        if (frames4.size() == 2) begin
            check("b2b_first", frames4[0], 8'h5A);
            check("b2b_second", frames4[1], 8'hFF);
        end
        repeat (3) cycle();

        // Tx_Valid pulse during a frame is ignored
        frames4.delete(); done_cnt4 = 0; early_ready = 0;
        tx_data4 = 8'hC3; tx_valid4 = 1'b1;
        cycle();
        tx_valid4 = 1'b0;
        n = 0;
        while (!done4 && n < 300) begin
            if (n == 10) begin tx_data4 = 8'h00; tx_valid4 = 1'b1; end
            if (n == 11) tx_valid4 = 1'b0;
            cycle();
            n++;
            if (tx_ready4 && !done4) early_ready++;
        end
        check("ign_ready_low_until_done", early_ready, 0);
        repeat (10) cycle();
        check("ign_cs_stays_high", cs_n4, 1'b1);
        check("ign_done_count", done_cnt4, 1);
        check("ign_frames", frames4.size(), 1);
        if (frames4.size() > 0) check("ign_data", frames4[0], 8'hC3);

        // Asynchronous reset after the 3rd SClk rise
        frames4.delete(); done_cnt4 = 0;
        tx_data4 = 8'h96; tx_valid4 = 1'b1;
        cycle();
        tx_valid4 = 1'b0;
        n = 0;
        while (bits4 < 3 && n < 300) begin cycle(); n++; end
        check("arst_reached_rise3", bits4, 3);
        #2 rst_n = 1'b0;
        #1;
        check("arst_cs_n", cs_n4, 1'b1);
        check("arst_sclk", sclk4, 1'b0);
        check("arst_mosi", mosi4, 1'b0);
        check("arst_busy", busy4, 1'b0);
        repeat (3) cycle();
        rst_n = 1'b1;
        repeat (2) cycle();
        check("arst_no_done", done_cnt4, 0);
        check("arst_no_frame", frames4.size(), 0);
        send4(8'hA5, lat);
        check("arst_next_latency", lat, 68);
        check("arst_next_frames", frames4.size(), 1);
        if (frames4.size() > 0) check("arst_next_data", frames4[0], 8'hA5);
        repeat (3) cycle();

        // CLK_DIV=1, 0x81
        tog1 = 0; bits1 = 0; word1 = '0; done_cnt1 = 0;
        tx_data1 = 8'h81; tx_valid1 = 1'b1;
        cycle();
        tx_valid1 = 1'b0;
        tx_data1  = 8'h00;
        n = 0;
        while (!done1 && n < 100) begin cycle(); n++; end
        check("div1_done_latency", n, 17);
        check("div1_sclk_toggles", tog1, 16);
        check("div1_rises", bits1, 8);
        check("div1_mosi_bits", word1, 8'h81);
        check("div1_rx_valid_at_done", rx_valid1, RX_EN);
        repeat (3) cycle();
        check("div1_idle", {cs_n1, busy1, tx_ready1, sclk1}, 4'b1010);
        check("div1_rx_data", rx_data1, 8'h00);

        // MISO capture of 0x3C, changing on SClk falls
        miso_word = 8'h3C; miso_idx = 7; miso4 = miso_word[7];
        cycle();
        send4(8'h69, lat);
        check("rx_latency", lat, 68);
        check("rx_valid_with_done", rx_valid4, RX_EN);
        check("rx_data", rx_data4, RX_EN ? 8'h3C : 8'h00);
        repeat (4) cycle();
        check("rx_valid_one_cycle", rx_valid4, 1'b0);
        check("rx_data_holds", rx_data4, RX_EN ? 8'h3C : 8'h00);
        check("rx_valid_count", rxv_cnt4, RX_EN ? 1 : 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
